// File: rtl/display_scanner_pkg.sv
// Shared definitions for the display scanner: scan state encoding and width helpers.
package display_scanner_pkg;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } scan_state_t;

    // Counter must hold max(DWELL_CYCLES, GAP_CYCLES) - 1; never narrower than one bit.
    function automatic int cnt_width(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/display_scanner.sv
// Multi-digit 7-segment scan controller with gap blanking and frame-synchronous updates.
// Optional leading-zero suppression is compiled in with DISPLAY_LZS_EN.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic [NUM_DIGITS-1:0]   DigitMask,
    output logic [3:0]              Binary,
    output logic [NUM_DIGITS-1:0]   DigitSel,
    output logic                    Frame
);

    localparam int CW = cnt_width(DWELL_CYCLES, GAP_CYCLES);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

    scan_state_t             state;
    logic [IW-1:0]           index;
    logic                    restart;
    logic [4*NUM_DIGITS-1:0] shadow_value, active_value;
    logic [NUM_DIGITS-1:0]   shadow_mask, active_mask, eff_mask;

    logic                    tc, show_done, gap_done, boundary, timer_load;
    logic [CW-1:0]           timer_value;
    logic [IW-1:0]           next_index;
    logic [4*NUM_DIGITS-1:0] new_value, entry_value;
    logic [NUM_DIGITS-1:0]   new_mask, sel_show;
    logic [3:0]              entry_nibble;

    // restart marks the first cycle after reset, which is itself a frame boundary.
    assign show_done   = (state == ST_SHOW) && tc && !restart;
    assign gap_done    = (state == ST_GAP) && tc && !restart;
    assign boundary    = restart || (show_done && (index == LAST_IDX));
    assign next_index  = boundary ? '0 : index + 1'b1;
    assign new_value   = Load ? Value : shadow_value;
    assign new_mask    = Load ? DigitMask : shadow_mask;
    assign entry_value = boundary ? new_value : active_value;
    assign timer_load  = restart || show_done || gap_done;
    assign timer_value = gap_done ? DWELL_LOAD : GAP_LOAD;

`ifdef DISPLAY_LZS_EN
    logic [NUM_DIGITS-1:0] supp_mask, new_supp;
    logic                  zero_above;

    // A digit goes dark when it and every more significant nibble are zero; digit 0 always shows.
    always_comb begin
        new_supp   = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above && (new_value[4*k +: 4] == 4'h0);
            new_supp[k] = zero_above;
        end
    end

    assign eff_mask = active_mask & ~supp_mask;
`else
    assign eff_mask = active_mask;
`endif

    always_comb begin
        entry_nibble = 4'h0;
        sel_show     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == next_index) entry_nibble = entry_value[4*k +: 4];
            sel_show[k] = (IW'(k) == index) && eff_mask[k];
        end
    end

    scan_timer #(.WIDTH(CW)) u_timer (
        .clk        (CLK),
        .rst        (RST),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_GAP;
            index        <= '0;
            restart      <= 1'b1;
            shadow_value <= '0;
            shadow_mask  <= '0;
            active_value <= '0;
            active_mask  <= '0;
`ifdef DISPLAY_LZS_EN
            supp_mask    <= '0;
`endif
            Binary       <= 4'h0;
            DigitSel     <= '0;
            Frame        <= 1'b0;
        end else begin
            Frame <= 1'b0;
            if (Load) begin
                shadow_value <= Value;
                shadow_mask  <= DigitMask;
            end
            if (restart || show_done) begin
                state    <= ST_GAP;
                index    <= next_index;
                restart  <= 1'b0;
                Binary   <= entry_nibble;
                DigitSel <= '0;
                if (boundary) begin
                    active_value <= new_value;
                    active_mask  <= new_mask;
`ifdef DISPLAY_LZS_EN
                    supp_mask    <= new_supp;
`endif
                end
            end else if (gap_done) begin
                state    <= ST_SHOW;
                DigitSel <= sel_show;
                Frame    <= (index == '0);
            end
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner (4 digits, dwell 8, gap 2): per-cycle expected {Binary, DigitSel, Frame}.
module tb_display_scanner;

    localparam int N = 4;
    localparam int D = 8;
    localparam int G = 2;
    localparam int W = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  mask;
    logic [3:0]  binary;
    logic [3:0]  sel;
    logic        frame;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_scanner #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (D),
        .GAP_CYCLES   (G)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .Load      (load),
        .Value     (value),
        .DigitMask (mask),
        .Binary    (binary),
        .DigitSel  (sel),
        .Frame     (frame)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Expected trace of one frame (first n cycles), starting at the GAP entry of digit 0.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] m, input int n);
        logic [3:0]   m_eff;
        logic [W-1:0] e;
        logic         zero_above;
        int           cnt;
        m_eff      = m;
        zero_above = 1'b1;
`ifdef DISPLAY_LZS_EN
        for (int d = N - 1; d >= 1; d--) begin
            zero_above = zero_above && (v[4*d +: 4] == 4'h0);
            if (zero_above) m_eff[d] = 1'b0;
        end
`endif
        cnt = 0;
        for (int d = 0; d < N; d++) begin
            for (int j = 0; j < G + D; j++) begin
                if (cnt < n) begin
                    e[8:5] = v[4*d +: 4];
                    e[4:1] = (j >= G && m_eff[d]) ? 4'(1 << d) : 4'b0000;
                    e[0]   = (d == 0 && j == G);
                    exp_q.push_back(e);
                end
                cnt++;
            end
        end
    endtask

    // Runs one full frame, optionally pulsing Load in up to two cycles of it.
    task automatic run_frame(input logic [15:0] v, input logic [3:0] m,
                             input int c1, input logic [15:0] v1, input logic [3:0] m1,
                             input int c2, input logic [15:0] v2, input logic [3:0] m2);
        push_frame(v, m, N * (G + D));
        for (int j = 0; j < N * (G + D); j++) begin
            if (j == c1) begin
                load = 1'b1; value = v1; mask = m1;
            end
            if (j == c2) begin
                load = 1'b1; value = v2; mask = m2;
            end
            cyc();
            load = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {binary, sel, frame};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL scan_out @%0t: got bin=%h sel=%b frame=%b, required bin=%h sel=%b frame=%b",
                         $time, got[8:5], got[4:1], got[0], e[8:5], e[4:1], e[0]);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        mask  = 4'h0;

        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_q.push_back('0);
        end
        rst = 1'b0;
        cyc();

        run_frame(16'h0000, 4'h0,  5, 16'h1234, 4'hF, -1, 16'h0, 4'h0);
        run_frame(16'h1234, 4'hF, 15, 16'hABCD, 4'hF, -1, 16'h0, 4'h0);
        run_frame(16'hABCD, 4'hF, 20, 16'h9999, 4'hF, 39, 16'h5678, 4'hF);
        run_frame(16'h5678, 4'hF,  3, 16'h5678, 4'b0101, -1, 16'h0, 4'h0);
        run_frame(16'h5678, 4'b0101, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Reset while digit 2 is lit, then restart with a load on the restart boundary.
        push_frame(16'h5678, 4'b0101, 25);
        repeat (24) cyc();
        rst = 1'b1;
        cyc();
        exp_q.push_back('0);
        rst   = 1'b0;
        load  = 1'b1;
        value = 16'h0000;
        mask  = 4'hF;
        cyc();
        load = 1'b0;

        run_frame(16'h0000, 4'hF, 10, 16'h0070, 4'hF, -1, 16'h0, 4'h0);
        run_frame(16'h0070, 4'hF, 10, 16'h1000, 4'hF, -1, 16'h0, 4'h0);
        run_frame(16'h1000, 4'hF, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexed scan controller for a common-segment multi-digit 7-segment display.
- Holds a multi-digit hex value and selects one digit at a time with one-hot enables.
- Presents that digit's 4-bit nibble on Binary, which feeds the 7-segment decoder directly downstream.
- Inserts a blanking gap between digits to prevent ghosting; new values take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..8; digit 0 is least significant (rightmost).
- DWELL_CYCLES, 50000: CLK cycles a digit's enable is held high; must be >= 1.
- GAP_CYCLES, 16: CLK cycles with all enables low before each digit; must be >= 1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Load  in  1  single-cycle strobe; captures Value and DigitMask into the shadow register.
- Value  in  4*NUM_DIGITS  hex value; nibble k (bits 4k+3:4k) belongs to digit k.
- DigitMask  in  NUM_DIGITS  per-digit enable; bit k = 0 keeps digit k dark.
- Binary  out  4  nibble of the current digit, to the decoder input; registered.
- DigitSel  out  NUM_DIGITS  one-hot active-high digit enable; registered; all-zero during gap.
- Frame  out  1  one-cycle pulse on the first cycle of digit 0's SHOW phase.

Behaviour:
- Reset (RST=1 at an edge): shadow, active value, masks, index, counter, Binary, DigitSel and Frame all become 0; state = GAP with index 0. RST overrides every other input.
- Shadow register: on Load=1, shadow <= {Value, DigitMask} on the next edge. It has no effect on the display until the next frame boundary.
- Two states, GAP and SHOW; a down-counter times each state.
- GAP: DigitSel = 0. Binary already holds active nibble[index]. After GAP_CYCLES cycles, go to SHOW.
- SHOW: DigitSel = one-hot(index) AND activeMask[index]. After DWELL_CYCLES cycles, index advances (wraps NUM_DIGITS-1 -> 0) and the block goes to GAP.
- Binary is loaded on GAP entry and stays constant for the whole GAP+SHOW slot.
- Frame boundary = entering GAP with index 0, either by wrap or as the first cycle after reset.
  - At a frame boundary, active <= shadow.
  - If Load=1 on the same cycle as the boundary update, Value/DigitMask bypass the shadow and go straight to active (the new data wins).
  - Binary on that GAP entry uses the updated active value.
- Timing:
  - Slot length = GAP_CYCLES + DWELL_CYCLES.
  - Frame period = NUM_DIGITS x slot, constant regardless of masks.
  - Frame pulses exactly once per frame.
- A masked-off digit keeps its full time slot, with DigitSel low throughout.
- Load during GAP or SHOW never alters Binary or DigitSel within the current frame.
- Reset mid-SHOW or mid-GAP: outputs are 0 on the next edge, and scanning restarts from GAP with index 0 and a full GAP_CYCLES count.

Optional Feature:
- Macro: DISPLAY_LZS_EN (leading-zero suppression).
- With the macro defined: at each frame boundary, compute a suppress mask from the newly loaded active value.
  - Digit k is suppressed if every nibble from k up to NUM_DIGITS-1 is 0, and k != 0.
  - Suppressed digits behave exactly like masked-off digits; digit 0 is never suppressed.
- Without the macro: no suppression logic is present; only DigitMask gates DigitSel.

Decomposition:
- Shared include display_defs.vh holds:
  - state encodings ST_GAP and ST_SHOW;
  - localparam for counter width, clog2(max(DWELL_CYCLES, GAP_CYCLES));
  - localparam for index width, clog2(NUM_DIGITS).
- One natural sub-module: scan_timer, a loadable down-counter with a terminal-count pulse, instantiated once. Everything else stays in display_scanner.

Test Plan (NUM_DIGITS=4, DWELL_CYCLES=8, GAP_CYCLES=2, slot 10, frame 40):
- Reset: hold RST 3 cycles -> Binary=0, DigitSel=0, Frame=0. After release, with mask 0, DigitSel stays 0 for 40 cycles while Frame pulses every 40 cycles.
- Basic scan: Load Value=16'h1234, DigitMask=4'hF.
  - Required from the next frame: Binary 4,3,2,1; DigitSel 0001, 0010, 0100, 1000, each high 8 cycles, separated by 2-cycle all-zero gaps.
  - Frame pulses coincide with DigitSel=0001 rising.
- Mid-frame load: after 16'h1234 is displaying, Load 16'hABCD while digit 1 shows -> digits 2,3 still show 2,1; the next frame shows D,C,B,A.
- Boundary collision and masking:
  - Load 16'h5678 in the exact cycle of the frame boundary -> that frame shows 8,7,6,5.
  - DigitMask=4'b0101 -> only 0001 and 0100 pulse, slot timing unchanged.
- Reset mid-SHOW: assert RST while DigitSel=0100 -> next edge all outputs 0; after release, a 2-cycle gap, then digit 0 with Binary=0.
- DISPLAY_LZS_EN defined:
  - Value 16'h0070, mask F -> digits 0,1 enabled, digits 2,3 dark.
  - Value 16'h0000 -> only digit 0 lit, showing 0.
  - Value 16'h1000 -> all four lit.
